// File: rtl/counter_32bit_ctrl.sv
// Sequencing controller that owns the 32-bit count register and its run state.
// Optional prescaler enabled by defining COUNTER_CTRL_PRESCALE_EN.
module counter_32bit_ctrl #(
  parameter int WIDTH = 32,
  parameter int PRE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_auto_reload,
`ifdef COUNTER_CTRL_PRESCALE_EN
  input  logic [PRE_W-1:0] cfg_prescale,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};
  localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};

  state_e             state_q,   state_d;
  logic [WIDTH-1:0]   count_q,   count_d;
  logic               expire_q,  expire_d;
  logic [WIDTH-1:0]   period_q,  period_d;
  logic               auto_q,    auto_d;
  logic [PRE_W-1:0]   presc_q,   presc_d;
  logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic [PRE_W-1:0]   presc_in_s;
  logic               tick_s;
  logic               match_s;

  // Without the prescaler the divider is held at zero, so every RUN cycle ticks.
`ifdef COUNTER_CTRL_PRESCALE_EN
  assign presc_in_s = cfg_prescale;
`else
  assign presc_in_s = PRE_ZERO;
`endif

  assign tick_s  = (pre_cnt_q == presc_q);
  assign match_s = tick_s && (count_q == period_q);

  // Next-state, count and expire computation.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expire_d  = 1'b0;
    period_d  = period_q;
    auto_d    = auto_q;
    presc_d   = presc_q;
    pre_cnt_d = pre_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          period_d = cfg_period;
          auto_d   = cfg_auto_reload;
          presc_d  = presc_in_s;
          state_d  = S_ARMED;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARMED: begin
        // Abort wins if start and stop arrive together.
        if (stop) begin
          pre_cnt_d = PRE_ZERO;
          state_d   = S_IDLE;
        end else if (start) begin
          count_d   = CNT_ZERO;
          pre_cnt_d = PRE_ZERO;
          state_d   = S_RUN;
        end else begin
          state_d = S_ARMED;
        end
      end
      S_RUN: begin
        if (stop) begin
          count_d   = CNT_ZERO;
          pre_cnt_d = PRE_ZERO;
          state_d   = S_IDLE;
        end else if (match_s) begin
          expire_d  = 1'b1;
          pre_cnt_d = PRE_ZERO;
          if (auto_q) begin
            count_d = CNT_ZERO;
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
          end
        end else if (pause) begin
          state_d = S_HOLD;
        end else if (tick_s) begin
          count_d   = count_q + CNT_ONE;
          pre_cnt_d = PRE_ZERO;
        end else begin
          pre_cnt_d = pre_cnt_q + PRE_ONE;
        end
      end
      S_HOLD: begin
        if (stop) begin
          count_d   = CNT_ZERO;
          pre_cnt_d = PRE_ZERO;
          state_d   = S_IDLE;
        end else if (!pause) begin
          state_d = S_RUN;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      count_q   <= CNT_ZERO;
      expire_q  <= 1'b0;
      period_q  <= CNT_ZERO;
      auto_q    <= 1'b0;
      presc_q   <= PRE_ZERO;
      pre_cnt_q <= PRE_ZERO;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expire_q  <= expire_d;
      period_q  <= period_d;
      auto_q    <= auto_d;
      presc_q   <= presc_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  assign count     = count_q;
  assign expire    = expire_q;
  assign state     = state_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_HOLD);
  assign cfg_ready = (state_q == S_IDLE);

endmodule
